// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the payload and the stop bit.
module uart_tx #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DATA_BITS  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baudTick,
   input  logic                 txValid,
   input  logic [DATA_BITS-1:0] txData,
   output logic                 txReady,
   output logic                 serialOut,
   output logic                 busy,
   output logic                 txDone
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   localparam logic [3:0] TickLast = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] BitLast  = 3'(DATA_BITS - 1);

   state_e               state_q;
   logic [3:0]           tick_q;
   logic [3:0]           tick_d;
   logic [2:0]           bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 line_q;
   logic                 ready_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 bit_end;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q;
`endif

   // The counter only runs while a frame is in flight; IDLE keeps it at zero.
   always_comb begin
      bit_end = 1'b0;
      tick_d  = tick_q;
      if (state_q != StIdle && baudTick) begin
         if (tick_q == TickLast) begin
            bit_end = 1'b1;
            tick_d  = 4'd0;
         end else begin
            tick_d  = tick_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         tick_q   <= 4'd0;
         bit_q    <= 3'd0;
         shift_q  <= '0;
         line_q   <= 1'b1;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         tick_q <= tick_d;
         unique case (state_q)
            StIdle: begin
               // A tick coinciding with the accept is deliberately not counted.
               if (txValid) begin
                  state_q  <= StStart;
                  shift_q  <= txData;
                  line_q   <= 1'b0;
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  tick_q   <= 4'd0;
                  bit_q    <= 3'd0;
`ifdef UART_TX_PARITY_EN
                  parity_q <= ^txData;
`endif
               end
            end
            StStart: begin
               if (bit_end) begin
                  state_q <= StData;
                  line_q  <= shift_q[0];
               end
            end
            StData: begin
               if (bit_end) begin
                  shift_q <= shift_q >> 1;
                  if (bit_q == BitLast) begin
                     bit_q   <= 3'd0;
`ifdef UART_TX_PARITY_EN
                     state_q <= StParity;
                     line_q  <= parity_q;
`else
                     state_q <= StStop;
                     line_q  <= 1'b1;
`endif
                  end else begin
                     bit_q  <= bit_q + 3'd1;
                     line_q <= shift_q[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               if (bit_end) begin
                  state_q <= StStop;
                  line_q  <= 1'b1;
               end
            end
`endif
            StStop: begin
               if (bit_end) begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               line_q  <= 1'b1;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               tick_q  <= 4'd0;
               bit_q   <= 3'd0;
            end
         endcase
      end
   end

   assign txReady   = ready_q;
   assign serialOut = line_q;
   assign busy      = busy_q;
   assign txDone    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame waveform, parity, back-to-back, slow ticks, stalls, reset abort.
module tb_uart_tx;
   localparam int OS = 16;
   localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = DB + 3;
`else
   localparam int NBITS = DB + 2;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          baudTick = 1'b0;
   logic          txValid = 1'b0;
   logic [DB-1:0] txData = '0;
   logic          txReady;
   logic          serialOut;
   logic          busy;
   logic          txDone;

   int checks = 0;
   int errors = 0;
   int phase  = 0;

   always #5 clk = ~clk;

   uart_tx #(
      .OVERSAMPLE(OS),
      .DATA_BITS (DB)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .baudTick (baudTick),
      .txValid  (txValid),
      .txData   (txData),
      .txReady  (txReady),
      .serialOut(serialOut),
      .busy     (busy),
      .txDone   (txDone)
   );

   function automatic logic exp_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= DB) return d[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == DB + 1) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic drive_tick(input int cyc, input int period, input int stall);
      if (cyc < stall) begin
         baudTick = 1'b0;
      end else begin
         baudTick = ((phase % period) == period - 1);
         phase++;
      end
   endtask

   // Accepts one frame and checks every cycle until the txDone cycle (returned in done_cyc).
   task automatic run_frame(input logic [7:0] data, input int period, input int stall,
                            input int change_at, input logic [7:0] alt, input bit keep_valid,
                            input string name, output int done_cyc);
      int  ticks = 0;
      int  cyc   = 0;
      int  limit = NBITS * OS * period + stall + 8;
      bit  done  = 1'b0;
      logic e;
      done_cyc = -1;
      txData   = data;
      txValid  = 1'b1;
      baudTick = 1'b1;
      phase    = 0;
      @(posedge clk);
      while (!done && cyc <= limit) begin
         @(negedge clk);
         if (cyc > 0) ticks += int'(baudTick);
         if (cyc == 0 && !keep_valid) txValid = 1'b0;
         if (cyc == change_at) txData = alt;
         if (ticks == NBITS * OS) begin
            done = 1'b1;
            done_cyc = cyc;
            checks++;
            if (txDone !== 1'b1 || busy !== 1'b0 || txReady !== 1'b1 || serialOut !== 1'b1) begin
               errors++;
               $display("FAIL %s end cyc=%0d txDone=%b busy=%b txReady=%b serialOut=%b, want 1 0 1 1",
                        name, cyc, txDone, busy, txReady, serialOut);
            end
         end else begin
            e = exp_bit(data, ticks / OS);
            checks++;
            if (serialOut !== e || txDone !== 1'b0 || busy !== 1'b1 || txReady !== 1'b0) begin
               errors++;
               $display("FAIL %s cyc=%0d serialOut=%b txDone=%b busy=%b txReady=%b, want %b 0 1 0",
                        name, cyc, serialOut, txDone, busy, txReady, e);
            end
            drive_tick(cyc, period, stall);
         end
         cyc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no txDone within %0d cycles, wanted one", name, limit);
      end
   endtask

   task automatic check_idle(input string name);
      @(negedge clk);
      checks++;
      if (txDone !== 1'b0 || txReady !== 1'b1 || busy !== 1'b0 || serialOut !== 1'b1) begin
         errors++;
         $display("FAIL %s idle: txDone=%b txReady=%b busy=%b serialOut=%b, want 0 1 0 1",
                  name, txDone, txReady, busy, serialOut);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      txValid = 1'b1;
      txData = 8'h5A;
      baudTick = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (serialOut !== 1'b1 || txReady !== 1'b1 || busy !== 1'b0 || txDone !== 1'b0) begin
         errors++;
         $display("FAIL reset: serialOut=%b txReady=%b busy=%b txDone=%b, want 1 1 0 0",
                  serialOut, txReady, busy, txDone);
      end
      txValid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (serialOut !== 1'b1 || txReady !== 1'b1 || busy !== 1'b0 || txDone !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: serialOut=%b txReady=%b busy=%b txDone=%b, want 1 1 0 0",
                  serialOut, txReady, busy, txDone);
      end
   endtask

   task automatic test_frame_55();
      int dc;
      run_frame(8'h55, 1, 0, -1, 8'h00, 1'b0, "frame55", dc);
      checks++;
      if (dc !== NBITS * OS) begin
         errors++;
         $display("FAIL frame55_latency: txDone at %0d, want %0d", dc, NBITS * OS);
      end
      check_idle("frame55");
   endtask

   task automatic test_parity();
      int dc;
      run_frame(8'h07, 1, 0, -1, 8'h00, 1'b0, "frame07", dc);
      checks++;
      if (dc !== NBITS * OS) begin
         errors++;
         $display("FAIL frame07_latency: txDone at %0d, want %0d", dc, NBITS * OS);
      end
      check_idle("frame07");
   endtask

   task automatic test_back_to_back();
      int dc1;
      int dc2;
      run_frame(8'hA3, 1, 0, 20, 8'h3C, 1'b1, "b2b_first", dc1);
      run_frame(8'h3C, 1, 0, -1, 8'h00, 1'b0, "b2b_second", dc2);
      checks++;
      if (dc2 !== NBITS * OS) begin
         errors++;
         $display("FAIL b2b_latency: second txDone at %0d, want %0d", dc2, NBITS * OS);
      end
      check_idle("b2b");
   endtask

   task automatic test_slow_tick();
      int dc;
      run_frame(8'hFF, 4, 0, -1, 8'h00, 1'b0, "slow_ff", dc);
      checks++;
      if (dc !== NBITS * OS * 4) begin
         errors++;
         $display("FAIL slow_latency: txDone at %0d, want %0d", dc, NBITS * OS * 4);
      end
      check_idle("slow_ff");
   endtask

   task automatic test_stall();
      int dc;
      run_frame(8'h3A, 1, 100, -1, 8'h00, 1'b0, "stall", dc);
      checks++;
      if (dc !== 100 + NBITS * OS) begin
         errors++;
         $display("FAIL stall_latency: txDone at %0d, want %0d", dc, 100 + NBITS * OS);
      end
      check_idle("stall");
   endtask

   task automatic test_reset_abort();
      int dc;
      int pulses = 0;
      txData = 8'h81;
      txValid = 1'b1;
      baudTick = 1'b1;
      @(posedge clk);
      @(negedge clk);
      txValid = 1'b0;
      repeat (OS + 50) @(negedge clk);
      checks++;
      if (serialOut !== 1'b0) begin
         errors++;
         $display("FAIL abort_pre: serialOut=%b, want 0", serialOut);
      end
      rst = 1'b0;
      txValid = 1'b1;
      @(negedge clk);
      checks++;
      if (serialOut !== 1'b1 || txReady !== 1'b1 || busy !== 1'b0 || txDone !== 1'b0) begin
         errors++;
         $display("FAIL abort: serialOut=%b txReady=%b busy=%b txDone=%b, want 1 1 0 0",
                  serialOut, txReady, busy, txDone);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_valid_in_reset: busy=%b, want 0", busy);
      end
      txValid = 1'b0;
      rst = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (txDone === 1'b1 || busy !== 1'b0) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL abort_quiet: %0d cycles with txDone/busy set, want 0", pulses);
      end
      run_frame(8'h81, 1, 0, -1, 8'h00, 1'b0, "after_abort", dc);
      check_idle("after_abort");
   endtask

   initial begin
      test_reset();
      test_frame_55();
      test_parity();
      test_back_to_back();
      test_slow_tick();
      test_stall();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
